data_ram_ctrl: RTL
==================

// Module: data_ram_ctrl
// PURPOSE
//  Multi-cycle data-RAM controller directly downstream of the MEM stage; consumes its ram_addr/ram_data/ram_w_request/ram_ce outputs.
//  Owns the data memory array; models RD_LAT read wait states and raises stall_req_o to freeze the pipeline until the access completes.
//  Stores run as read phase then write phase: read word is returned on ram_data_o, MEM merges SB/SH bytes, controller commits merged word.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width (`ADDR_WIDTH)
//  DATA_WIDTH  32  word width (`DATA_WIDTH)
//  DEPTH_LOG2  12  log2 of array depth in words (4096 words = 16 KiB)
//  RD_LAT      2   read wait-state cycles, legal range 1..15
// PORTS
//  clk_i            in   1           clock, all state updates on rising edge
//  rst_i            in   1           synchronous reset, active-high
//  ram_ce_i         in   1           chip enable from MEM (`CHIP_ENABLE = access request)
//  ram_w_request_i  in   1           1 = store, 0 = load; sampled with ce in IDLE
//  ram_addr_i       in   ADDR_WIDTH  byte address from MEM
//  ram_data_i       in   DATA_WIDTH  merged write word from MEM; sampled only in WR
//  ram_data_o       out  DATA_WIDTH  read word (registered) back to MEM
//  stall_req_o      out  1           1 = hold PC/IF/ID/EX/EXE_MEM/MEM inputs
//  busy_o           out  1           1 = state != IDLE (debug/perf)
// BEHAVIOUR
//  Reset (rst_i=1 at edge): state=IDLE, cnt=0, addr_q=0, we_q=0, rdata_q=0 -> ram_data_o=0, busy_o=0; stall_req_o=0 while ce=0.
//  Array contents are NOT reset. Reset mid-access aborts it; a write commits only if WR's edge occurred before reset.
//  Word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored (alignment handled by MEM); upper bits ignored -> aliasing/wrap.
//  FSM states IDLE, RD_WAIT, WR, DONE:
//   IDLE:    if ram_ce_i: addr_q<=ram_addr_i, we_q<=ram_w_request_i, cnt<=RD_LAT-1, ->RD_WAIT. Else stay.
//   RD_WAIT: if cnt==0: rdata_q<=mem[idx(addr_q)], ->WR if we_q else ->DONE. Else cnt<=cnt-1.
//   WR:      mem[idx(addr_q)]<=ram_data_i at end of cycle; ->DONE. ram_data_o = pre-store word for the merge.
//   DONE:    ->IDLE unconditionally; ce still high here is the SAME request and is NOT re-accepted.
//  stall_req_o (combinational) = (state==IDLE & ram_ce_i) | state==RD_WAIT | state==WR; 0 in DONE.
//  Cycles: load = RD_LAT+2 incl. DONE, stalled RD_LAT+1; store = RD_LAT+3, stalled RD_LAT+2.
//  ram_data_o valid in WR and DONE; holds last read value otherwise.
//  Inputs changing while busy are ignored (addr_q/we_q latched); only ram_data_i is live, in WR.
//  Back-to-back: request present in cycle after DONE is accepted from IDLE; no bubble beyond DONE.
//  Load immediately after store to same word returns the stored value (write precedes the next read phase).
//  ram_ce_i=0 in IDLE: no array access, stall_req_o=0, outputs hold.
// STRUCTURE
//  defines.v additions: `RAM_DEPTH_LOG2 (12), `RAM_RD_LAT (2); reuse `CHIP_ENABLE/`WRITE_ENABLE/`ZERO.
//  State encoding and cnt width ($clog2(RD_LAT+1)) are localparams in this module, not shared.
//  One sub-module: data_ram_array (single-port sync word array, we/addr/wdata/rdata, registered read).
//  Controller FSM + counter + latches in this module; stall_req_o is the only combinational output.
// TESTING
//  1 Reset: hold rst_i 2 cycles with ce=1 -> ram_data_o=0, busy_o=0, stall_req_o=1 only after rst drops with ce=1.
//  2 LW: preload mem[0x10>>2]=0xDEADBEEF, ce=1 we=0 addr=0x10, RD_LAT=2 -> stall 3 cycles, DONE cycle ram_data_o=0xDEADBEEF, stall=0.
//  3 SB RMW: word 0x11223344 @0x20, store via MEM byte 0xAA offset 1 -> WR sees ram_data_o=0x11223344, commits 0x1122AA44; following LW reads 0x1122AA44.
//  4 Back-to-back SW 0x0000CAFE @0x40 then LW @0x40 -> no lost/duplicated request, load returns 0x0000CAFE, exactly one write observed.
//  5 Reset mid-store: assert rst_i during RD_WAIT -> mem[@0x20] unchanged, state IDLE next cycle, stall drops.
//  6 Alias/ignore: addr=0x4003 with DEPTH_LOG2=12 -> accesses word 0 (addr[13:2]=0); input addr changed mid-RD_WAIT -> latched addr used.

Source files
------------

// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared defaults and enable encodings for the data-RAM controller
package data_ram_pkg;
  localparam int RAM_ADDR_WIDTH = 32;
  localparam int RAM_DATA_WIDTH = 32;
  localparam int RAM_DEPTH_LOG2 = 12;
  localparam int RAM_RD_LAT = 2;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
endpackage

// File: rtl/data_ram_array.sv
// data_ram_array: single-port word array with registered read (read-old on write)
module data_ram_array
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int DEPTH_LOG2 = RAM_DEPTH_LOG2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: multi-cycle data-RAM controller with read wait states, RMW stores and pipeline stall
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int DEPTH_LOG2 = RAM_DEPTH_LOG2,
  parameter int RD_LAT = RAM_RD_LAT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ram_ce_i,
  input  logic                  ram_w_request_i,
  input  logic [ADDR_WIDTH-1:0] ram_addr_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  stall_req_o,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_e;
  localparam int CW = $clog2(RD_LAT + 1);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic we_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic busy_q;
  logic req;
  logic arr_we;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic unused_addr;
  assign req = ram_ce_i == CHIP_ENABLE;
  assign arr_we = state_q == WR && !rst_i;
  assign arr_addr = state_q == IDLE ? ram_addr_i[DEPTH_LOG2+1:2] : addr_q[DEPTH_LOG2+1:2];
  assign unused_addr = ^{addr_q[ADDR_WIDTH-1:DEPTH_LOG2+2], addr_q[1:0]};
  assign stall_req_o = !rst_i && ((state_q == IDLE && req) || state_q == RD_WAIT || state_q == WR);
  assign ram_data_o = rdata_q;
  assign busy_o = busy_q;
  data_ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (arr_we),
    .addr_i (arr_addr),
    .wdata_i(ram_data_i),
    .rdata_o(arr_rdata)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      rdata_q <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          addr_q <= ram_addr_i;
          we_q <= ram_w_request_i == WRITE_ENABLE;
          cnt_q <= CW'(RD_LAT - 1);
          state_q <= RD_WAIT;
          busy_q <= 1'b1;
        end
        RD_WAIT: if (cnt_q == '0) begin
          rdata_q <= arr_rdata;
          state_q <= we_q ? WR : DONE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        WR: state_q <= DONE;
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
